cordic_iter_ctrl: RTL and testbench
===================================

# cordic_iter_ctrl

Iterative sequencer for a single registered CORDIC micro-rotation stage (inputs a/b/p/q, shift, microangle, dec_angle; outputs ax/by/px/qy, outangle). It accepts one vectoring job, feeds the stage's registered outputs back into its inputs for ITERS consecutive cycles, and steps the shift index and arctangent constant each cycle. It then returns the final vector pair and the accumulated angle with a one-cycle valid pulse. It sits between the job source and one shared iteration stage, replacing a fully unrolled pipeline where area matters.

## Interface
- N, 31: MSB index of the vector operands; width is N+1, signed.
- ITERS, 16: micro-rotations per job; legal range 1..16, limited by the 4-bit shift.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request; accepted only when ready=1.
- ready  out  1  high in IDLE only.
- x_in, y_in, p_in, q_in  in  N+1  signed job operands (x,y is the steering pair).
- x_out, y_out, p_out, q_out  out  N+1  signed results.
- angle_out  out  16  accumulated angle, degrees × 256, two's-complement wrap.
- out_valid  out  1  one-cycle result strobe.
- st_a, st_b, st_p, st_q  out  N+1  stage operand inputs.
- st_shift  out  4  stage shift amount.
- st_micro  out  16  stage microangle.
- st_dec  out  16  stage dec_angle.
- st_ax, st_by, st_px, st_qy  in  N+1  stage registered outputs.
- st_angle  in  16  stage outangle.

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - ready=1.
  - start=1 latches x_in/y_in/p_in/q_in into operand registers, clears idx to 0, and moves to RUN.
- RUN
  - Operand source when idx=0: the latched operands, with st_dec=0.
  - Operand source when idx>0: st_ax/st_by/st_px/st_qy, with st_dec=st_angle.
  - st_shift=idx.
  - st_micro=ROM[idx], where ROM = 11520, 6801, 3593, 1824, 916, 458, 229, 115, 57, 29, 14, 7, 4, 2, 1, 0.
  - idx increments every edge.
  - On the edge where idx=ITERS-1, move to DONE.
- DONE
  - One cycle; the stage holds the result of the final micro-rotation.
  - On the exit edge, register st_ax/st_by/st_px/st_qy/st_angle into x_out/y_out/p_out/q_out/angle_out, pulse out_valid, and return to IDLE.
- In IDLE and DONE, st_* outputs hold the latched operands, with st_shift=0, st_micro=0, st_dec=0. Stage outputs are ignored outside RUN/DONE.
- Arithmetic is performed in the stage. The controller does no arithmetic other than the idx increment, and does no gain compensation; the magnitude carries the ≈1.6468 CORDIC gain.
- start while ready=0 is ignored and not queued.

## Timing
- Reset values: state=IDLE, idx=0, ready=1, out_valid=0, all x/y/p/q_out=0, angle_out=0, operand registers=0.
- Accept edge E0 (start=1, ready=1). RUN occupies the cycles after E0..E_ITERS-1. DONE is the cycle after E_ITERS. out_valid rises at E_ITERS+1.
- Latency from the accept edge to out_valid high: ITERS+1 cycles.
- out_valid is exactly one cycle. Results hold until the next out_valid.
- ready falls at E0 and rises at E_ITERS+1, the same edge as out_valid. A start in that cycle is accepted at the next edge.
- Minimum start-to-start spacing is ITERS+2 cycles.
- No backpressure: out_valid cannot be stalled.
- Reset mid-job aborts immediately. No out_valid is produced, and outputs return to 0.
- ITERS=1: RUN lasts one cycle, and out_valid follows 2 cycles after accept.

## Test plan
- Reset during idle and mid-RUN (idx=7) -> ready=1, out_valid=0, all outputs 0, no strobe afterwards.
- x_in=4096, y_in=4096, p=q=0, ITERS=16 -> out_valid exactly 17 cycles after accept; angle_out=11520±4; x_out≈9539±8; y_out within ±4 of 0.
- x_in=4096, y_in=-4096 -> angle_out=54016±4 (−45°, wrapped); x_out≈9539±8.
- Monitor stage ports during one job -> st_shift=0..15 in order and st_micro matches the ROM sequence. st_dec=0 at idx 0, then equals the previous st_angle.
- start held high continuously -> jobs accepted every 18 cycles; starts during busy are dropped; ready and out_valid coincide.
- ITERS=4 build with x_in=y_in=1000 -> latency 5 cycles; st_micro sequence is 11520, 6801, 3593, 1824; angle_out equals the stage's accumulated value after 4 rotations.

Source files
------------

// File: rtl/cordic_iter_if.sv
// Job-side bus of the iterative CORDIC sequencer: request operands in,
// final vector pair and accumulated angle out.
interface cordic_iter_if #(
    parameter int N = 31
);
    logic                start;
    logic                ready;
    logic signed [N:0]   x_in;
    logic signed [N:0]   y_in;
    logic signed [N:0]   p_in;
    logic signed [N:0]   q_in;
    logic signed [N:0]   x_out;
    logic signed [N:0]   y_out;
    logic signed [N:0]   p_out;
    logic signed [N:0]   q_out;
    logic        [15:0]  angle_out;
    logic                out_valid;

    // Job source side
    modport master (
        output start, x_in, y_in, p_in, q_in,
        input  ready, x_out, y_out, p_out, q_out, angle_out, out_valid
    );

    // Sequencer side
    modport slave (
        input  start, x_in, y_in, p_in, q_in,
        output ready, x_out, y_out, p_out, q_out, angle_out, out_valid
    );
endinterface

// File: rtl/cordic_iter_ctrl.sv
// Iterative sequencer for one shared, registered CORDIC micro-rotation stage.
// A job's operands are fed into the stage once, then the stage's registered
// outputs are looped back for ITERS cycles while the shift index and the
// arctangent constant step. The final vector pair and accumulated angle are
// captured with a one-cycle valid strobe. No gain compensation is applied.
module cordic_iter_ctrl #(
    parameter int N     = 31,
    parameter int ITERS = 16
) (
    input  logic               clk,
    input  logic               rst,
    cordic_iter_if.slave       job,
    output logic signed [N:0]  st_a,
    output logic signed [N:0]  st_b,
    output logic signed [N:0]  st_p,
    output logic signed [N:0]  st_q,
    output logic        [3:0]  st_shift,
    output logic        [15:0] st_micro,
    output logic        [15:0] st_dec,
    input  logic signed [N:0]  st_ax,
    input  logic signed [N:0]  st_by,
    input  logic signed [N:0]  st_px,
    input  logic signed [N:0]  st_qy,
    input  logic        [15:0] st_angle
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(ITERS - 1);

    // atan(2^-i) in degrees x 256
    function automatic logic [15:0] micro_angle(input logic [3:0] i);
        logic [15:0] a;
        case (i)
            4'd0:    a = 16'd11520;
            4'd1:    a = 16'd6801;
            4'd2:    a = 16'd3593;
            4'd3:    a = 16'd1824;
            4'd4:    a = 16'd916;
            4'd5:    a = 16'd458;
            4'd6:    a = 16'd229;
            4'd7:    a = 16'd115;
            4'd8:    a = 16'd57;
            4'd9:    a = 16'd29;
            4'd10:   a = 16'd14;
            4'd11:   a = 16'd7;
            4'd12:   a = 16'd4;
            4'd13:   a = 16'd2;
            4'd14:   a = 16'd1;
            default: a = 16'd0;
        endcase
        return a;
    endfunction

    state_t             state_q;
    state_t             state_d;
    logic [3:0]         idx_q;
    logic [3:0]         idx_d;
    logic               load_ops;
    logic               load_res;

    logic signed [N:0]  op_x_p0;
    logic signed [N:0]  op_y_p0;
    logic signed [N:0]  op_p_p0;
    logic signed [N:0]  op_q_p0;

    // State and iteration index registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: accept in IDLE, step idx in RUN, one DONE cycle
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        load_ops = 1'b0;
        load_res = 1'b0;
        case (state_q)
            IDLE: begin
                if (job.start) begin
                    load_ops = 1'b1;
                    idx_d    = 4'd0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                idx_d = idx_q + 4'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                load_res = 1'b1;
                idx_d    = 4'd0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = 4'd0;
            end
        endcase
    end

    assign job.ready = (state_q == IDLE);

    // Capture job operands at the accept edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_x_p0 <= '0;
            op_y_p0 <= '0;
            op_p_p0 <= '0;
            op_q_p0 <= '0;
        end else if (load_ops) begin
            op_x_p0 <= job.x_in;
            op_y_p0 <= job.y_in;
            op_p_p0 <= job.p_in;
            op_q_p0 <= job.q_in;
        end
    end

    // Stage input mux: latched operands first, then the stage's own feedback
    always_comb begin
        st_a     = op_x_p0;
        st_b     = op_y_p0;
        st_p     = op_p_p0;
        st_q     = op_q_p0;
        st_shift = 4'd0;
        st_micro = 16'd0;
        st_dec   = 16'd0;
        if (state_q == RUN) begin
            st_shift = idx_q;
            st_micro = micro_angle(idx_q);
            if (idx_q != 4'd0) begin
                st_a   = st_ax;
                st_b   = st_by;
                st_p   = st_px;
                st_q   = st_qy;
                st_dec = st_angle;
            end
        end
    end

    // Result capture and one-cycle strobe on leaving DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job.x_out     <= '0;
            job.y_out     <= '0;
            job.p_out     <= '0;
            job.q_out     <= '0;
            job.angle_out <= 16'd0;
            job.out_valid <= 1'b0;
        end else begin
            job.out_valid <= load_res;
            if (load_res) begin
                job.x_out     <= st_ax;
                job.y_out     <= st_by;
                job.p_out     <= st_px;
                job.q_out     <= st_qy;
                job.angle_out <= st_angle;
            end
        end
    end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl: a registered CORDIC stage model closes the loop
// around the sequencer, and a job-level reference model predicts every
// cycle's handshake, stage-port and result values.
module tb_cordic_iter_ctrl;
    localparam int N  = 31;
    localparam int W  = N + 1;
    localparam int IT = 16;
    localparam int RW = 4 * W + 16;

    typedef logic [RW-1:0] res_t;

    localparam logic [15:0] ROM_T [0:15] = '{
        16'd11520, 16'd6801, 16'd3593, 16'd1824, 16'd916, 16'd458, 16'd229, 16'd115,
        16'd57, 16'd29, 16'd14, 16'd7, 16'd4, 16'd2, 16'd1, 16'd0
    };

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
        n_total++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    // One vectoring micro-rotation: steer by the sign of the second component
    function automatic void rot(
        input  logic signed [W-1:0] a, b, p, q,
        input  logic        [15:0]  dec,
        input  int                  sh,
        input  logic        [15:0]  mic,
        output logic signed [W-1:0] ax, by, px, qy,
        output logic        [15:0]  ang
    );
        if (b >= 0) begin
            ax  = a + (b >>> sh);
            by  = b - (a >>> sh);
            px  = p + (q >>> sh);
            qy  = q - (p >>> sh);
            ang = dec + mic;
        end else begin
            ax  = a - (b >>> sh);
            by  = b + (a >>> sh);
            px  = p - (q >>> sh);
            qy  = q + (p >>> sh);
            ang = dec - mic;
        end
    endfunction

    // Whole-job result: ITERS rotations starting from angle 0
    function automatic res_t job_model(input logic signed [W-1:0] x, y, p, q, input int iters);
        logic signed [W-1:0] a, b, c, d, na, nb, nc, nd;
        logic [15:0] g, ng;
        a = x; b = y; c = p; d = q; g = 16'd0;
        for (int i = 0; i < iters; i++) begin
            rot(a, b, c, d, g, i, ROM_T[i], na, nb, nc, nd, ng);
            a = na; b = nb; c = nc; d = nd; g = ng;
        end
        return {a, b, c, d, g};
    endfunction

    function automatic logic signed [W-1:0] rnd_op();
        int unsigned u;
        u = $urandom_range(0, 32'h1FFF_FFFF);
        return $signed(u) - 32'sh1000_0000;
    endfunction

    // ---------------- main DUT (ITERS=16) and its stage ----------------
    cordic_iter_if #(.N(N)) jb();
    logic signed [W-1:0] st_a, st_b, st_p, st_q;
    logic [3:0]  st_shift;
    logic [15:0] st_micro, st_dec;
    logic signed [W-1:0] s_ax = '0, s_by = '0, s_px = '0, s_qy = '0;
    logic [15:0] s_ang = '0;
    logic signed [W-1:0] n_ax, n_by, n_px, n_qy;
    logic [15:0] n_ang;

    cordic_iter_ctrl #(.N(N), .ITERS(IT)) u_dut (
        .clk(clk), .rst(rst), .job(jb),
        .st_a(st_a), .st_b(st_b), .st_p(st_p), .st_q(st_q),
        .st_shift(st_shift), .st_micro(st_micro), .st_dec(st_dec),
        .st_ax(s_ax), .st_by(s_by), .st_px(s_px), .st_qy(s_qy), .st_angle(s_ang)
    );

    always_comb rot(st_a, st_b, st_p, st_q, st_dec, int'(st_shift), st_micro,
                    n_ax, n_by, n_px, n_qy, n_ang);

    always @(posedge clk) begin
        s_ax <= n_ax; s_by <= n_by; s_px <= n_px; s_qy <= n_qy; s_ang <= n_ang;
    end

    // ---------------- small DUT (ITERS=4) and its stage ----------------
    cordic_iter_if #(.N(N)) jb4();
    logic signed [W-1:0] st4_a, st4_b, st4_p, st4_q;
    logic [3:0]  st4_shift;
    logic [15:0] st4_micro, st4_dec;
    logic signed [W-1:0] s4_ax = '0, s4_by = '0, s4_px = '0, s4_qy = '0;
    logic [15:0] s4_ang = '0;
    logic signed [W-1:0] n4_ax, n4_by, n4_px, n4_qy;
    logic [15:0] n4_ang;

    cordic_iter_ctrl #(.N(N), .ITERS(4)) u_dut4 (
        .clk(clk), .rst(rst), .job(jb4),
        .st_a(st4_a), .st_b(st4_b), .st_p(st4_p), .st_q(st4_q),
        .st_shift(st4_shift), .st_micro(st4_micro), .st_dec(st4_dec),
        .st_ax(s4_ax), .st_by(s4_by), .st_px(s4_px), .st_qy(s4_qy), .st_angle(s4_ang)
    );

    always_comb rot(st4_a, st4_b, st4_p, st4_q, st4_dec, int'(st4_shift), st4_micro,
                    n4_ax, n4_by, n4_px, n4_qy, n4_ang);

    always @(posedge clk) begin
        s4_ax <= n4_ax; s4_by <= n4_by; s4_px <= n4_px; s4_qy <= n4_qy; s4_ang <= n4_ang;
    end

    // ---------------- reference model for the main DUT ----------------
    // m_cnt counts edges since the accept edge; busy until ITERS+1 edges.
    logic m_busy;
    int   m_cnt;
    logic m_vld;
    logic signed [W-1:0] m_x, m_y, m_p, m_q;
    res_t m_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_cnt <= 0; m_vld <= 1'b0;
            m_x <= '0; m_y <= '0; m_p <= '0; m_q <= '0; m_res <= '0;
        end else begin
            m_vld <= 1'b0;
            if (!m_busy) begin
                if (jb.start) begin
                    m_busy <= 1'b1; m_cnt <= 0;
                    m_x <= jb.x_in; m_y <= jb.y_in; m_p <= jb.p_in; m_q <= jb.q_in;
                end
            end else if (m_cnt == IT) begin
                m_busy <= 1'b0;
                m_vld  <= 1'b1;
                m_res  <= job_model(m_x, m_y, m_p, m_q, IT);
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    logic signed [W-1:0] e_x, e_y, e_p, e_q;
    logic [15:0] e_a;
    assign e_x = m_res[RW-1 -: W];
    assign e_y = m_res[RW-1-W -: W];
    assign e_p = m_res[RW-1-2*W -: W];
    assign e_q = m_res[RW-1-3*W -: W];
    assign e_a = m_res[15:0];

    // ---------------- per-cycle compare ----------------
    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", longint'(jb.ready), longint'(!m_busy));
            check("out_valid", longint'(jb.out_valid), longint'(m_vld));
            check("x_out", jb.x_out, e_x);
            check("y_out", jb.y_out, e_y);
            check("p_out", jb.p_out, e_p);
            check("q_out", jb.q_out, e_q);
            check("angle_out", longint'(jb.angle_out), longint'(e_a));
            if (m_busy && m_cnt < IT) begin
                check("st_shift", longint'(st_shift), longint'(m_cnt));
                check("st_micro", longint'(st_micro), longint'(ROM_T[m_cnt]));
                if (m_cnt == 0) begin
                    check("st_dec0", longint'(st_dec), 0);
                    check("st_a0", st_a, m_x);
                    check("st_b0", st_b, m_y);
                    check("st_p0", st_p, m_p);
                    check("st_q0", st_q, m_q);
                end else begin
                    check("st_dec", longint'(st_dec), longint'(s_ang));
                    check("st_a", st_a, s_ax);
                    check("st_b", st_b, s_by);
                    check("st_p", st_p, s_px);
                    check("st_q", st_q, s_qy);
                end
            end else begin
                check("st_shift_idle", longint'(st_shift), 0);
                check("st_micro_idle", longint'(st_micro), 0);
                check("st_dec_idle", longint'(st_dec), 0);
                check("st_a_idle", st_a, m_x);
                check("st_q_idle", st_q, m_q);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready();
        int g = 0;
        while (!jb.ready && g < 40) begin @(negedge clk); g++; end
        check("ready_wait", longint'(jb.ready), 1);
    endtask

    // Issue one job and wait for its strobe; returns edges from accept to strobe
    task automatic run_job(input logic signed [W-1:0] x, y, p, q, output int lat);
        wait_ready();
        jb.start = 1'b1; jb.x_in = x; jb.y_in = y; jb.p_in = p; jb.q_in = q;
        @(negedge clk);
        jb.start = 1'b0;
        lat = 0;
        while (!jb.out_valid && lat < 40) begin @(negedge clk); lat++; end
        check("latency", lat, IT + 1);
    endtask

    initial begin
        int lat, g, prev_rdy, n_acc, last_acc, n_ov, n_bad;
        rst = 1'b1;
        jb.start = 1'b0; jb.x_in = '0; jb.y_in = '0; jb.p_in = '0; jb.q_in = '0;
        jb4.start = 1'b0; jb4.x_in = '0; jb4.y_in = '0; jb4.p_in = '0; jb4.q_in = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", longint'(jb.ready), 1);
        check("rst_valid", longint'(jb.out_valid), 0);
        check("rst_x_out", jb.x_out, 0);
        check("rst_angle", longint'(jb.angle_out), 0);
        check("rst_st_a", st_a, 0);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // 45 degree vector
        run_job(32'sd4096, 32'sd4096, 32'sd0, 32'sd0, lat);
        check_rng("pin45_angle", longint'(jb.angle_out), 11516, 11524);
        check_rng("pin45_x", jb.x_out, 9531, 9547);
        check_rng("pin45_y", jb.y_out, -4, 4);
        check_rng("pin45_model_angle", longint'(e_a), 11516, 11524);

        // -45 degree vector, wrapped angle
        run_job(32'sd4096, -32'sd4096, 32'sd0, 32'sd0, lat);
        check_rng("pinm45_angle", longint'(jb.angle_out), 54012, 54020);
        check_rng("pinm45_x", jb.x_out, 9531, 9547);
        @(negedge clk);
        check("valid_one_cycle", longint'(jb.out_valid), 0);

        // Reset while idle
        #1 rst = 1'b1;
        @(negedge clk);
        check("rsti_ready", longint'(jb.ready), 1);
        check("rsti_x_out", jb.x_out, 0);
        check("rsti_angle", longint'(jb.angle_out), 0);
        #1 rst = 1'b0;

        // Reset mid-RUN at idx 7
        wait_ready();
        jb.start = 1'b1; jb.x_in = 32'sd5000; jb.y_in = -32'sd3000; jb.p_in = 32'sd7; jb.q_in = 32'sd9;
        @(negedge clk);
        jb.start = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_idx7", longint'(st_shift), 7);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rstr_ready", longint'(jb.ready), 1);
        check("rstr_valid", longint'(jb.out_valid), 0);
        check("rstr_y_out", jb.y_out, 0);
        #1 rst = 1'b0;
        n_ov = 0;
        for (int c = 0; c < 25; c++) begin @(negedge clk); if (jb.out_valid) n_ov++; end
        check("no_strobe_after_abort", n_ov, 0);

        // Randomized jobs with random idle gaps
        for (int j = 0; j < 20; j++) begin
            run_job(rnd_op(), rnd_op(), rnd_op(), rnd_op(), lat);
            g = $urandom_range(0, 3);
            repeat (g) @(negedge clk);
        end

        // start held high: accepts every IT+2 cycles, busy starts dropped
        wait_ready();
        jb.start = 1'b1;
        prev_rdy = 1; n_acc = 0; last_acc = -1; n_ov = 0; n_bad = 0;
        for (int c = 0; c < 60; c++) begin
            jb.x_in = rnd_op(); jb.y_in = rnd_op(); jb.p_in = rnd_op(); jb.q_in = rnd_op();
            @(negedge clk);
            if (prev_rdy == 1 && !jb.ready) begin
                if (last_acc >= 0) check("accept_spacing", c - last_acc, IT + 2);
                last_acc = c;
                n_acc++;
            end
            if (jb.out_valid) begin
                n_ov++;
                if (!jb.ready) n_bad++;
            end
            prev_rdy = int'(jb.ready);
        end
        jb.start = 1'b0;
        check("held_accepts", n_acc, 4);
        check("held_strobes", n_ov, 3);
        check("ready_with_valid", n_bad, 0);
        repeat (IT + 4) @(negedge clk);

        // ITERS=4 instance
        jb4.start = 1'b1; jb4.x_in = 32'sd1000; jb4.y_in = 32'sd1000; jb4.p_in = '0; jb4.q_in = '0;
        @(negedge clk);
        jb4.start = 1'b0;
        lat = 0;
        while (!jb4.out_valid && lat < 20) begin
            if (lat < 4) check("i4_micro", longint'(st4_micro), longint'(ROM_T[lat]));
            @(negedge clk);
            lat++;
        end
        check("i4_latency", lat, 5);
        check("i4_angle", longint'(jb4.angle_out), 12904);
        check("i4_x", jb4.x_out, 2313);
        check("i4_y", jb4.y_out, -219);
        check("i4_p", jb4.p_out, 0);
        begin
            res_t r4;
            r4 = job_model(32'sd1000, 32'sd1000, 32'sd0, 32'sd0, 4);
            check("i4_angle_model", longint'(jb4.angle_out), longint'(r4[15:0]));
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
